// File: rtl/mb8_arbiter_if.sv
// Bus interfaces around the mb8 memory-port arbiter.
//   mb8_req_if : requester side. Carries per-requester req/we/lock, the
//                packed addresses (ai) and write data (vi). It returns the
//                gnt vector, the rvld strobe vector and the shared rdata.
//                master = requesters, slave = arbiter.
//   mb8_mem_if : single byte-wide memory port. The arbiter drives
//                mem_we/mem_ai/mem_vi and the memory returns mem_vo one
//                cycle later.
//                master = arbiter, slave = memory.

interface mb8_req_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned ASZ  = 17,
    parameter int unsigned DSZ  = 8
);
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     we;
    logic [NREQ-1:0]     lock;
    logic [NREQ*ASZ-1:0] ai;
    logic [NREQ*DSZ-1:0] vi;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rvld;
    logic [DSZ-1:0]      rdata;

    modport master (output req, we, lock, ai, vi, input gnt, rvld, rdata);
    modport slave  (input req, we, lock, ai, vi, output gnt, rvld, rdata);
endinterface

interface mb8_mem_if #(
    parameter int unsigned ASZ = 17,
    parameter int unsigned DSZ = 8
);
    logic           mem_we;
    logic [ASZ-1:0] mem_ai;
    logic [DSZ-1:0] mem_vi;
    logic [DSZ-1:0] mem_vo;

    modport master (output mem_we, mem_ai, mem_vi, input mem_vo);
    modport slave  (input mem_we, mem_ai, mem_vi, output mem_vo);
endinterface

// File: rtl/mb8_arbiter.sv
// Round-robin arbiter that shares one byte-wide memory port among NREQ
// requesters. It supports per-requester lock bursts of up to MAXBURST grants.
//   clk, rst_n : clock, synchronous active-low reset
//   req_bus    : requester side (req/we/lock/ai/vi in; gnt/rvld/rdata out)
//                gnt is combinational. rvld is registered one cycle after a
//                granted read.
//   mem_bus    : memory master port (mem_we/mem_ai/mem_vi out, mem_vo in).
//                All memory-side outputs are combinational from the winner.

module mb8_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned ASZ      = 17,
    parameter int unsigned DSZ      = 8,
    parameter int unsigned MAXBURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mb8_req_if.slave    req_bus,
    mb8_mem_if.master   mem_bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW = $clog2(MAXBURST) + 1;

    typedef enum logic {FREE = 1'b0, OWNED = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [NREQ-1:0] rvld_q, rvld_d;

    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] req_m;
    logic [NREQ-1:0] owner_oh;
    logic            owner_keep;
    logic            found;
    logic            new_burst;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cidx;
    int unsigned     cand;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FREE;
            ptr_q   <= '0;
            owner_q <= '0;
            bcnt_q  <= '0;
            rvld_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            bcnt_q  <= bcnt_d;
            rvld_q  <= rvld_d;
        end
    end

    // Winner selection, burst bookkeeping and memory port mux
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        bcnt_d    = bcnt_q;
        gnt       = '0;
        found     = 1'b0;
        new_burst = 1'b0;
        win       = '0;
        cand      = 0;
        cidx      = '0;

        mem_bus.mem_we = 1'b0;
        mem_bus.mem_ai = '0;
        mem_bus.mem_vi = '0;

        owner_oh   = NREQ'(1) << owner_q;
        owner_keep = (state_q == OWNED) && req_bus.req[owner_q] &&
                     (bcnt_q < BW'(MAXBURST));

        // An owner that is not kept (burst exhausted or idle) is masked from this scan
        req_m = req_bus.req;
        if (state_q == OWNED && !owner_keep) begin
            req_m = req_bus.req & ~owner_oh;
        end

        if (owner_keep) begin
            found = 1'b1;
            win   = owner_q;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = (32'(ptr_q) + k) % NREQ;
                cidx = PW'(cand);
                if (!found && req_m[cidx]) begin
                    found = 1'b1;
                    win   = cidx;
                end
            end
            // Exhausted owner with nobody else waiting: grant it again as a fresh burst
            if (!found && state_q == OWNED && req_bus.req[owner_q]) begin
                found     = 1'b1;
                win       = owner_q;
                new_burst = 1'b1;
            end
        end

        if (found) begin
            gnt[win] = 1'b1;
            ptr_d    = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            if (req_bus.lock[win]) begin
                if (state_q == OWNED && win == owner_q && !new_burst) begin
                    bcnt_d = bcnt_q + BW'(1);
                end else begin
                    owner_d = win;
                    bcnt_d  = BW'(1);
                end
                state_d = OWNED;
            end else begin
                state_d = FREE;
                bcnt_d  = '0;
            end
        end else begin
            state_d = FREE;
            bcnt_d  = '0;
        end

        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mem_bus.mem_we = req_bus.we[i];
                mem_bus.mem_ai = req_bus.ai[i*ASZ +: ASZ];
                mem_bus.mem_vi = req_bus.vi[i*DSZ +: DSZ];
            end
        end

        rvld_d = gnt & ~req_bus.we;
    end

    assign req_bus.gnt   = gnt;
    assign req_bus.rvld  = rvld_q;
    assign req_bus.rdata = mem_bus.mem_vo;

endmodule
